// File: rtl/muldiv_ctrl_pkg.sv
// Shared defines for the mult/div controller: FSM states, op codes, stall
// encodings, the latched request payload and small op-decode helpers.
package muldiv_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // Stall request encodings
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic [1:0] {
    MuldivIdle = 2'd0,
    MuldivRun  = 2'd1,
    MuldivDone = 2'd2
  } muldiv_state_e;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } muldiv_op_e;

  typedef struct packed {
    muldiv_op_e      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } muldiv_req_t;

  // Divide ops have bit 1 set
  function automatic logic op_is_div(input muldiv_op_e op);
    return op[1];
  endfunction

  // Unsigned ops have bit 0 set
  function automatic logic op_is_signed(input muldiv_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_wdog.sv
// Watchdog run counter: counts enabled cycles from 0 and saturates at
// LIMIT-1, where expired is raised.
module muldiv_wdog #(
  parameter int unsigned LIMIT = 40,
  parameter int unsigned CNT_W = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register; clear has priority over counting
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Mult/div controller: latches an EX-stage request, holds the engine for the
// run, applies a watchdog, and writes HI/LO exactly once when EX advances.
// Optional feature macro: MULDIV_DIVZERO_BYPASS_EN (divide by zero skips the
// engine and completes with {a, 32'hFFFFFFFF}).
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            adv,
  input  logic            flush,
  output logic            stallreq,
  output logic            eng_start,
  output logic            eng_div,
  output logic            eng_signed,
  output logic [XLEN-1:0] eng_x,
  output logic [XLEN-1:0] eng_y,
  input  logic            eng_ready,
  input  logic [2*XLEN-1:0] eng_result,
  output logic            hi_we,
  output logic [XLEN-1:0] hi_wdata,
  output logic            lo_we,
  output logic [XLEN-1:0] lo_wdata,
  output logic            busy,
  output logic            err
);

  localparam int unsigned CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  muldiv_state_e     state_q, state_d;
  muldiv_req_t       req_q, req_d;
  logic [2*XLEN-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic              wd_clr, wd_en, wd_expired;

  assign wd_en  = (state_q == MuldivRun);
  assign wd_clr = (state_q != MuldivRun);

  muldiv_wdog #(
    .LIMIT (MAX_CYCLES),
    .CNT_W (CNT_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // State, latched request, result and error flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MuldivIdle;
      req_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Next-state and outputs; everything reads 0 while reset is held
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    res_d      = res_q;
    err_d      = err_q;
    stallreq   = NoStop;
    eng_start  = 1'b0;
    eng_div    = 1'b0;
    eng_signed = 1'b0;
    eng_x      = '0;
    eng_y      = '0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_wdata   = '0;
    lo_wdata   = '0;
    busy       = 1'b0;
    err        = 1'b0;
    if (!rst) begin
      busy = (state_q != MuldivIdle);
      unique case (state_q)
        MuldivIdle: begin
          if (req_valid && !flush) begin
            stallreq = Stop;
            req_d    = '{op: muldiv_op_e'(req_op), a: req_a, b: req_b};
            err_d    = 1'b0;
            state_d  = MuldivRun;
`ifdef MULDIV_DIVZERO_BYPASS_EN
            if (req_op[1] && (req_b == '0)) begin
              res_d   = {req_a, {XLEN{1'b1}}};
              state_d = MuldivDone;
            end
`endif
          end
        end
        MuldivRun: begin
          stallreq   = Stop;
          eng_start  = !flush;
          eng_div    = op_is_div(req_q.op);
          eng_signed = op_is_signed(req_q.op);
          eng_x      = req_q.a;
          eng_y      = req_q.b;
          if (flush) begin
            state_d = MuldivIdle;
          end else if (eng_ready) begin
            res_d   = eng_result;
            state_d = MuldivDone;
          end else if (wd_expired) begin
            err_d   = 1'b1;
            state_d = MuldivDone;
          end
        end
        MuldivDone: begin
          if (flush) begin
            state_d = MuldivIdle;
          end else if (adv) begin
            err     = err_q;
            state_d = MuldivIdle;
            if (!err_q) begin
              hi_we    = 1'b1;
              lo_we    = 1'b1;
              hi_wdata = res_q[2*XLEN-1:XLEN];
              lo_wdata = res_q[XLEN-1:0];
            end
          end
        end
        default: state_d = MuldivIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (MAX_CYCLES = 40).
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        adv, flush;
  logic        stallreq, eng_start, eng_div, eng_signed;
  logic [31:0] eng_x, eng_y;
  logic        eng_ready;
  logic [63:0] eng_result;
  logic        hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;
  logic        busy, err;

  int errors = 0;
  int checks = 0;
  int run_cycles;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MAX_CYCLES(40)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .adv        (adv),
    .flush      (flush),
    .stallreq   (stallreq),
    .eng_start  (eng_start),
    .eng_div    (eng_div),
    .eng_signed (eng_signed),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_ready  (eng_ready),
    .eng_result (eng_result),
    .hi_we      (hi_we),
    .hi_wdata   (hi_wdata),
    .lo_we      (lo_we),
    .lo_wdata   (lo_wdata),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_a      = '0;
    req_b      = '0;
    adv        = 1'b0;
    flush      = 1'b0;
    eng_ready  = 1'b0;
    eng_result = '0;
  endtask

  // Start a new cycle at the falling edge with quiet inputs
  task automatic tick();
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    rst = 1'b1;
    idle_in();

    // Reset: outputs stay low even with a request presented
    tick(); rst = 1'b1; req_valid = 1'b1; #1;
    chk("rst_stall", stallreq, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", eng_start, 0);
    tick(); rst = 1'b0; #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_hi_we", hi_we, 0);
    chk("post_rst_err", err, 0);
    chk("post_rst_eng_x", eng_x, 0);

    // Signed mult, engine ready on 2nd run cycle
    tick(); req_valid = 1'b1; req_op = 2'b00; req_a = 32'hFFFFFFFD; req_b = 32'd5; #1;
    chk("mult_acc_stall", stallreq, 1);
    chk("mult_acc_start", eng_start, 0);
    tick(); req_valid = 1'b1; #1;
    chk("mult_r1_stall", stallreq, 1);
    chk("mult_r1_start", eng_start, 1);
    chk("mult_r1_x", eng_x, 32'hFFFFFFFD);
    chk("mult_r1_y", eng_y, 32'd5);
    chk("mult_r1_div", eng_div, 0);
    chk("mult_r1_signed", eng_signed, 1);
    tick(); eng_ready = 1'b1; eng_result = 64'hFFFFFFFF_FFFFFFF1; #1;
    chk("mult_r2_stall", stallreq, 1);
    chk("mult_r2_hi_we", hi_we, 0);
    // DONE with adv; next op already presented but must not be taken here
    tick(); adv = 1'b1; req_valid = 1'b1; req_op = 2'b11; req_a = 32'd7; req_b = 32'd2; #1;
    chk("mult_done_stall", stallreq, 0);
    chk("mult_done_hi_we", hi_we, 1);
    chk("mult_done_lo_we", lo_we, 1);
    chk("mult_done_hi", hi_wdata, 32'hFFFFFFFF);
    chk("mult_done_lo", lo_wdata, 32'hFFFFFFF1);
    chk("mult_done_start", eng_start, 0);
    chk("mult_done_err", err, 0);

    // Divu accepted from IDLE one cycle later; DONE held 3 cycles
    tick(); req_valid = 1'b1; req_op = 2'b11; req_a = 32'd7; req_b = 32'd2; #1;
    chk("b2b_busy", busy, 0);
    chk("b2b_stall", stallreq, 1);
    chk("b2b_hi_we", hi_we, 0);
    for (int r = 0; r < 3; r++) begin
      tick(); req_valid = 1'b1; req_op = 2'b11;
      eng_ready = (r == 2); eng_result = 64'h00000001_00000003; #1;
      chk("divu_div", eng_div, 1);
      chk("divu_signed", eng_signed, 0);
      chk("divu_start", eng_start, 1);
      chk("divu_y", eng_y, 32'd2);
    end
    for (int d = 0; d < 3; d++) begin
      tick(); #1;
      chk("wait_hi_we", hi_we, 0);
      chk("wait_lo_we", lo_we, 0);
      chk("wait_stall", stallreq, 0);
      chk("wait_hi_wdata", hi_wdata, 0);
      chk("wait_busy", busy, 1);
    end
    tick(); adv = 1'b1; #1;
    chk("divu_hi_we", hi_we, 1);
    chk("divu_lo_we", lo_we, 1);
    chk("divu_hi", hi_wdata, 32'd1);
    chk("divu_lo", lo_wdata, 32'd3);
    tick(); #1;
    chk("divu_idle_busy", busy, 0);
    chk("divu_idle_hi_we", hi_we, 0);

    // Flush at run cycle 5 together with eng_ready and adv
    tick(); req_valid = 1'b1; req_op = 2'b10; req_a = 32'd100; req_b = 32'd7; #1;
    for (int r = 0; r < 4; r++) begin
      tick(); #1;
      chk("fl_run_start", eng_start, 1);
    end
    tick(); flush = 1'b1; eng_ready = 1'b1; eng_result = 64'h2_0000000E; adv = 1'b1; #1;
    chk("fl_start", eng_start, 0);
    chk("fl_hi_we", hi_we, 0);
    chk("fl_lo_we", lo_we, 0);
    tick(); adv = 1'b1; #1;
    chk("fl_next_busy", busy, 0);
    chk("fl_next_hi_we", hi_we, 0);
    chk("fl_next_lo_we", lo_we, 0);
    tick(); req_valid = 1'b1; flush = 1'b1; #1;
    chk("fl_idle_stall", stallreq, 0);
    tick(); #1;
    chk("fl_idle_busy", busy, 0);

    // Watchdog: engine never ready
    tick(); req_valid = 1'b1; req_op = 2'b00; req_a = 32'd3; req_b = 32'd4; #1;
    run_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      tick(); #1;
      if (!(busy && stallreq)) break;
      run_cycles++;
    end
    chk("wd_run_cycles", run_cycles, 40);
    chk("wd_done_busy", busy, 1);
    chk("wd_done_err_noadv", err, 0);
    chk("wd_done_hi_we", hi_we, 0);
    tick(); adv = 1'b1; #1;
    chk("wd_err_pulse", err, 1);
    chk("wd_adv_hi_we", hi_we, 0);
    chk("wd_adv_lo_we", lo_we, 0);
    tick(); #1;
    chk("wd_after_err", err, 0);
    chk("wd_after_busy", busy, 0);

    // Divide by zero
    tick(); req_valid = 1'b1; req_op = 2'b10; req_a = 32'h12345678; req_b = 32'd0; #1;
    chk("dz_acc_stall", stallreq, 1);
`ifdef MULDIV_DIVZERO_BYPASS_EN
    tick(); #1;
    chk("dz_done_start", eng_start, 0);
    chk("dz_done_busy", busy, 1);
    chk("dz_done_stall", stallreq, 0);
    tick(); adv = 1'b1; #1;
    chk("dz_adv_start", eng_start, 0);
`else
    tick(); #1;
    chk("dz_run_start", eng_start, 1);
    chk("dz_run_x", eng_x, 32'h12345678);
    chk("dz_run_y", eng_y, 0);
    chk("dz_run_div", eng_div, 1);
    tick(); eng_ready = 1'b1; eng_result = 64'h12345678_FFFFFFFF; #1;
    tick(); adv = 1'b1; #1;
`endif
    chk("dz_hi_we", hi_we, 1);
    chk("dz_hi", hi_wdata, 32'h12345678);
    chk("dz_lo", lo_wdata, 32'hFFFFFFFF);
    tick(); #1;
    chk("dz_idle_busy", busy, 0);

    // Reset in the middle of a run abandons it
    tick(); req_valid = 1'b1; req_op = 2'b01; req_a = 32'd9; req_b = 32'd9; #1;
    tick(); #1;
    chk("rr_busy", busy, 1);
    tick(); rst = 1'b1; eng_ready = 1'b1; eng_result = 64'h0_00000051; adv = 1'b1; #1;
    chk("rr_start", eng_start, 0);
    chk("rr_stall", stallreq, 0);
    chk("rr_hi_we", hi_we, 0);
    chk("rr_eng_x", eng_x, 0);
    tick(); rst = 1'b0; adv = 1'b1; #1;
    chk("rr_after_busy", busy, 0);
    chk("rr_after_hi_we", hi_we, 0);
    chk("rr_after_eng_x", eng_x, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
